execution_stage: RTL and testbench
==================================

EXECUTION_STAGE -- requirements
Module: execution_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 opcode  in  11  instruction bits [31:21] for control decode.
REQ-004 reg2loc, b, bz, bnz, mem_read, mem_to_reg, mem_write, reg_write  out  1 each  combinational control decode of opcode.
REQ-005 alu_op  out  2  combinational; alu_src  out  2  combinational.
REQ-006 in_buf  in  299  ID/EX packet, one field per bit range:
- [63:0] PC
- [95:64] instruction
- [159:96] sign-extended immediate
- [223:160] data1
- [287:224] data2
- [289:288] alu_src
- [291:290] alu_op
- 292 b; 293 bz; 294 bnz; 295 mem_write; 296 mem_read; 297 mem_to_reg; 298 reg_write
REQ-007 data2write  out  64  write-back value.
REQ-008 reg2write  out  5  destination register.
REQ-009 reg_write_out  out  1  write-back enable.
REQ-010 branch_address  out  64  branch target.
REQ-011 pc_src  out  1  branch taken.

Function
REQ-012 Control decode SHALL be purely combinational; an unmatched opcode SHALL drive all control outputs 0.
REQ-013 R-type control: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
- reg_write=1, alu_op=10, alu_src=00; all other control outputs 0.
REQ-014 LDUR 11111000010 control:
- mem_read=1, mem_to_reg=1, reg_write=1, alu_src=01, alu_op=00; all other control outputs 0.
REQ-015 STUR 11111000000 control:
- mem_write=1, reg2loc=1, alu_src=01, alu_op=00; all other control outputs 0.
REQ-016 Branch control:
- CBZ 10110100xxx: bz=1, reg2loc=1, alu_op=01.
- CBNZ 10110101xxx: bnz=1, reg2loc=1, alu_op=01.
- B 000101xxxxx: b=1.
- All other control outputs 0 for these opcodes.
REQ-017 ALU operand B selection: data2 when alu_src=00 or 10; sign-extended immediate when alu_src=01.
REQ-018 ALU operation:
- alu_op=00: data1+B.
- alu_op=01: pass B.
- alu_op=10: function by in_buf[95:85] (ADD, SUB, AND, ORR per REQ-013); any other code gives 0.
- alu_op=11: 0.
- Arithmetic is 64-bit, wrap-around, no flags beyond zero.
REQ-019 zero = (ALU result == 0).
REQ-020 Data memory: 32 x 64-bit doublewords, indexed by ALU result [7:3]; low address bits ignored; address wraps modulo 256 bytes.
REQ-021 Store: on a rising edge with in_buf mem_write=1, mem[index] <= data2.
REQ-022 Load: read is combinational from current memory contents.
REQ-023 Outputs SHALL register on each rising edge (latency 1 cycle from in_buf):
- data2write <= mem_to_reg ? memory read data : ALU result.
- reg2write <= instruction[4:0].
- reg_write_out <= in_buf reg_write.
REQ-024 Branch outputs SHALL register on the same edge:
- branch_address <= PC + (immediate << 2).
- pc_src <= b | (bz & zero) | (bnz & ~zero).
REQ-025 A store followed next cycle by a load to the same index SHALL return the stored value.
REQ-026 When mem_write=0, memory SHALL be unchanged.
REQ-027 Simultaneous b and bz/bnz: pc_src SHALL be 1 whenever b=1.

Reset
REQ-028 While rst_n=0, all registered outputs SHALL be 0 and all 32 memory words SHALL clear to 0, asynchronously.
REQ-029 Reset asserted mid-operation SHALL discard the in-flight packet; the first capture after rst_n rises is on the next rising edge.
REQ-030 The combinational control outputs SHALL be unaffected by reset.

Verification
REQ-031 opcode=11111000010 -> mem_read=1, mem_to_reg=1, reg_write=1, alu_src=01, alu_op=00, others 0; opcode=00000000000 -> all 0.
REQ-032 ADD packet with data1=5, data2=7, rd=3 -> after one edge: data2write=12, reg2write=3, reg_write_out=1, pc_src=0.
REQ-033 SUB packet with data1=0, data2=1 -> data2write=0xFFFFFFFFFFFFFFFF (wrap-around).
REQ-034 STUR with data1=0, imm=8, data2=0xABCD, then LDUR with data1=0, imm=8, rd=9 -> data2write=0xABCD, reg2write=9.
REQ-035 CBZ with PC=0x100, imm=4:
- data2=0 -> pc_src=1, branch_address=0x110.
- data2=1 -> pc_src=0.
- CBNZ under the same two conditions gives the opposite pc_src.
REQ-036 Assert rst_n=0 between clock edges after a store -> all outputs 0 immediately; subsequent LDUR of that index returns 0.

Source files
------------

// File: rtl/execution_stage_if.sv
// Bus between the decode/ID-EX side and the execution stage: opcode decode,
// the ID/EX packet, and the registered write-back/branch results.
interface execution_stage_if;
  logic [10:0]  opcode;
  logic         reg2loc;
  logic         b;
  logic         bz;
  logic         bnz;
  logic         mem_read;
  logic         mem_to_reg;
  logic         mem_write;
  logic         reg_write;
  logic [1:0]   alu_op;
  logic [1:0]   alu_src;
  logic [298:0] in_buf;
  logic [63:0]  data2write;
  logic [4:0]   reg2write;
  logic         reg_write_out;
  logic [63:0]  branch_address;
  logic         pc_src;

  modport slave (
    input  opcode, in_buf,
    output reg2loc, b, bz, bnz, mem_read, mem_to_reg, mem_write, reg_write,
    output alu_op, alu_src,
    output data2write, reg2write, reg_write_out, branch_address, pc_src
  );

  modport master (
    output opcode, in_buf,
    input  reg2loc, b, bz, bnz, mem_read, mem_to_reg, mem_write, reg_write,
    input  alu_op, alu_src,
    input  data2write, reg2write, reg_write_out, branch_address, pc_src
  );
endinterface

// File: rtl/execution_stage.sv
// LEGv8-style execute stage: combinational control decode, 64-bit ALU,
// 32-doubleword data memory and registered write-back/branch outputs.
module execution_stage (
  input  logic              clk,
  input  logic              rst_n,
  execution_stage_if.slave  bus
);
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  // ---------------- control decode (independent of reset) ----------------
  logic       ctl_reg2loc, ctl_b, ctl_bz, ctl_bnz;
  logic       ctl_mem_read, ctl_mem_to_reg, ctl_mem_write, ctl_reg_write;
  logic [1:0] ctl_alu_op, ctl_alu_src;

  always_comb begin
    ctl_reg2loc    = 1'b0;
    ctl_b          = 1'b0;
    ctl_bz         = 1'b0;
    ctl_bnz        = 1'b0;
    ctl_mem_read   = 1'b0;
    ctl_mem_to_reg = 1'b0;
    ctl_mem_write  = 1'b0;
    ctl_reg_write  = 1'b0;
    ctl_alu_op     = 2'b00;
    ctl_alu_src    = 2'b00;
    casez (bus.opcode)
      OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
        ctl_reg_write = 1'b1;
        ctl_alu_op    = 2'b10;
      end
      OP_LDUR: begin
        ctl_mem_read   = 1'b1;
        ctl_mem_to_reg = 1'b1;
        ctl_reg_write  = 1'b1;
        ctl_alu_src    = 2'b01;
      end
      OP_STUR: begin
        ctl_mem_write = 1'b1;
        ctl_reg2loc   = 1'b1;
        ctl_alu_src   = 2'b01;
      end
      11'b10110100???: begin
        ctl_bz      = 1'b1;
        ctl_reg2loc = 1'b1;
        ctl_alu_op  = 2'b01;
      end
      11'b10110101???: begin
        ctl_bnz     = 1'b1;
        ctl_reg2loc = 1'b1;
        ctl_alu_op  = 2'b01;
      end
      11'b000101?????: ctl_b = 1'b1;
      default: ;
    endcase
  end

  assign bus.reg2loc    = ctl_reg2loc;
  assign bus.b          = ctl_b;
  assign bus.bz         = ctl_bz;
  assign bus.bnz        = ctl_bnz;
  assign bus.mem_read   = ctl_mem_read;
  assign bus.mem_to_reg = ctl_mem_to_reg;
  assign bus.mem_write  = ctl_mem_write;
  assign bus.reg_write  = ctl_reg_write;
  assign bus.alu_op     = ctl_alu_op;
  assign bus.alu_src    = ctl_alu_src;

  // ---------------- ID/EX packet fields ----------------
  logic [63:0] pc, imm, data1, data2;
  logic [10:0] fn_code;
  logic [4:0]  rd;
  logic [1:0]  pkt_alu_src, pkt_alu_op;
  logic        pkt_b, pkt_bz, pkt_bnz, pkt_mem_write, pkt_mem_to_reg, pkt_reg_write;
  logic        unused_bits;

  assign pc             = bus.in_buf[63:0];
  assign rd             = bus.in_buf[68:64];
  assign fn_code        = bus.in_buf[95:85];
  assign imm            = bus.in_buf[159:96];
  assign data1          = bus.in_buf[223:160];
  assign data2          = bus.in_buf[287:224];
  assign pkt_alu_src    = bus.in_buf[289:288];
  assign pkt_alu_op     = bus.in_buf[291:290];
  assign pkt_b          = bus.in_buf[292];
  assign pkt_bz         = bus.in_buf[293];
  assign pkt_bnz        = bus.in_buf[294];
  assign pkt_mem_write  = bus.in_buf[295];
  assign pkt_mem_to_reg = bus.in_buf[297];
  assign pkt_reg_write  = bus.in_buf[298];
  // mem_read has no effect because memory reads are always combinational
  assign unused_bits    = ^{bus.in_buf[84:69], bus.in_buf[296]};

  // ---------------- ALU ----------------
  logic [63:0] operand_b, alu_result;
  logic        zero;

  always_comb begin
    operand_b  = (pkt_alu_src == 2'b01) ? imm : data2;
    alu_result = '0;
    case (pkt_alu_op)
      2'b00: alu_result = data1 + operand_b;
      2'b01: alu_result = operand_b;
      2'b10: begin
        case (fn_code)
          OP_ADD:  alu_result = data1 + operand_b;
          OP_SUB:  alu_result = data1 - operand_b;
          OP_AND:  alu_result = data1 & operand_b;
          OP_ORR:  alu_result = data1 | operand_b;
          default: alu_result = '0;
        endcase
      end
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == 64'd0);

  // ---------------- data memory ----------------
  // Register-based so the whole array can clear asynchronously on reset.
  logic [63:0] mem [32];
  logic [4:0]  mem_index;
  logic [63:0] mem_rdata;

  assign mem_index = alu_result[7:3];
  assign mem_rdata = mem[mem_index];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (pkt_mem_write) begin
      mem[mem_index] <= data2;
    end
  end

  // ---------------- EX/WB registers ----------------
  logic [63:0] data2write_reg, branch_address_reg;
  logic [4:0]  reg2write_reg;
  logic        reg_write_out_reg, pc_src_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data2write_reg     <= '0;
      reg2write_reg      <= '0;
      reg_write_out_reg  <= 1'b0;
      branch_address_reg <= '0;
      pc_src_reg         <= 1'b0;
    end else begin
      data2write_reg     <= pkt_mem_to_reg ? mem_rdata : alu_result;
      reg2write_reg      <= rd;
      reg_write_out_reg  <= pkt_reg_write;
      branch_address_reg <= pc + (imm << 2);
      pc_src_reg         <= pkt_b | (pkt_bz & zero) | (pkt_bnz & ~zero);
    end
  end

  assign bus.data2write     = data2write_reg;
  assign bus.reg2write      = reg2write_reg;
  assign bus.reg_write_out  = reg_write_out_reg;
  assign bus.branch_address = branch_address_reg;
  assign bus.pc_src         = pc_src_reg;
endmodule

// File: tb/tb_execution_stage.sv
// Self-checking bench for execution_stage: decode table, directed packet
// table, reset-mid-operation sequence, and random packets vs. a reference model.
module tb_execution_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  execution_stage_if bus ();
  execution_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef enum int {K_ADD, K_SUB, K_AND, K_ORR, K_LDUR, K_STUR, K_CBZ, K_CBNZ, K_B, K_NOP} kind_t;

  typedef struct {
    logic [63:0] d;
    logic        rw;
    logic        ps;
    logic [63:0] ba;
  } exp_t;

  typedef struct {
    logic [10:0] op;
    logic [11:0] ctl;
  } dec_vec_t;

  typedef struct {
    kind_t       k;
    logic [4:0]  rd;
    logic [63:0] pc, imm, d1, d2;
    exp_t        e;
  } pkt_vec_t;

  logic [63:0] model_mem [32];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // control vector order {reg2loc,b,bz,bnz,mem_read,mem_to_reg,mem_write,reg_write,alu_op,alu_src}
  function automatic logic [11:0] ctl_model(logic [10:0] op);
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) return 12'b0000_0001_1000;
    if (op == 11'b11111000010) return 12'b0000_1101_0001;
    if (op == 11'b11111000000) return 12'b1000_0010_0001;
    if (op[10:3] == 8'b10110100) return 12'b1010_0000_0100;
    if (op[10:3] == 8'b10110101) return 12'b1001_0000_0100;
    if (op[10:5] == 6'b000101) return 12'b0100_0000_0000;
    return 12'b0;
  endfunction

  function automatic logic [11:0] ctl_vec();
    return {bus.reg2loc, bus.b, bus.bz, bus.bnz, bus.mem_read, bus.mem_to_reg,
            bus.mem_write, bus.reg_write, bus.alu_op, bus.alu_src};
  endfunction

  function automatic logic [10:0] op_of(kind_t k);
    case (k)
      K_ADD:  return 11'b10001011000;
      K_SUB:  return 11'b11001011000;
      K_AND:  return 11'b10001010000;
      K_ORR:  return 11'b10101010000;
      K_LDUR: return 11'b11111000010;
      K_STUR: return 11'b11111000000;
      K_CBZ:  return 11'b10110100011;
      K_CBNZ: return 11'b10110101110;
      K_B:    return 11'b00010110101;
      default: return 11'b11111111111;
    endcase
  endfunction

  function automatic logic [298:0] make_pkt(logic [10:0] op, logic [4:0] rd,
                                            logic [63:0] pc, logic [63:0] imm,
                                            logic [63:0] d1, logic [63:0] d2);
    logic [11:0] c;
    logic [31:0] instr;
    c = ctl_model(op);
    instr = {op, 16'h5A3C, rd};
    return {c[4], c[6], c[7], c[5], c[8], c[9], c[10], c[3:2], c[1:0], d2, d1, imm, instr, pc};
  endfunction

  // Instruction-level meaning of each packet
  function automatic exp_t predict(kind_t k, logic [63:0] pc, logic [63:0] imm,
                                   logic [63:0] d1, logic [63:0] d2);
    exp_t e;
    logic [63:0] addr;
    addr = d1 + imm;
    case (k)
      K_ADD:  e.d = d1 + d2;
      K_SUB:  e.d = d1 - d2;
      K_AND:  e.d = d1 & d2;
      K_ORR:  e.d = d1 | d2;
      K_LDUR: e.d = model_mem[(addr % 256) / 8];
      K_STUR: e.d = addr;
      K_CBZ, K_CBNZ: e.d = d2;
      default: e.d = d1 + d2;
    endcase
    e.rw = (k == K_ADD || k == K_SUB || k == K_AND || k == K_ORR || k == K_LDUR);
    e.ps = (k == K_B) || (k == K_CBZ && d2 == 0) || (k == K_CBNZ && d2 != 0);
    e.ba = pc + imm * 4;
    return e;
  endfunction

  task automatic run_pkt(string tag, kind_t k, logic [4:0] rd, logic [63:0] pc,
                         logic [63:0] imm, logic [63:0] d1, logic [63:0] d2, exp_t e);
    logic [10:0] op;
    logic [63:0] addr;
    op = op_of(k);
    @(negedge clk);
    bus.opcode = op;
    bus.in_buf = make_pkt(op, rd, pc, imm, d1, d2);
    #1 check({tag, ".ctl"}, 64'(ctl_vec()), 64'(ctl_model(op)));
    @(posedge clk);
    #1;
    check({tag, ".data2write"}, bus.data2write, e.d);
    check({tag, ".reg2write"}, 64'(bus.reg2write), 64'(rd));
    check({tag, ".reg_write_out"}, 64'(bus.reg_write_out), 64'(e.rw));
    check({tag, ".pc_src"}, 64'(bus.pc_src), 64'(e.ps));
    check({tag, ".branch_address"}, bus.branch_address, e.ba);
    $display("%s kind=%0d rd=%0d d1=%h d2=%h imm=%h -> wb=%h pc_src=%0b", tag, k, rd, d1, d2,
             imm, bus.data2write, bus.pc_src);
    if (k == K_STUR) begin
      addr = d1 + imm;
      model_mem[(addr % 256) / 8] = d2;
    end
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, ".data2write"}, bus.data2write, 64'd0);
    check({tag, ".reg2write"}, 64'(bus.reg2write), 64'd0);
    check({tag, ".reg_write_out"}, 64'(bus.reg_write_out), 64'd0);
    check({tag, ".pc_src"}, 64'(bus.pc_src), 64'd0);
    check({tag, ".branch_address"}, bus.branch_address, 64'd0);
  endtask

  dec_vec_t dec_tab [12];
  pkt_vec_t pkt_tab [15];

  function automatic exp_t mk(logic [63:0] d, logic rw, logic ps, logic [63:0] ba);
    exp_t e;
    e.d = d; e.rw = rw; e.ps = ps; e.ba = ba;
    return e;
  endfunction

  function automatic pkt_vec_t pv(kind_t k, logic [4:0] rd, logic [63:0] pc, logic [63:0] imm,
                                  logic [63:0] d1, logic [63:0] d2, exp_t e);
    pkt_vec_t p;
    p.k = k; p.rd = rd; p.pc = pc; p.imm = imm; p.d1 = d1; p.d2 = d2; p.e = e;
    return p;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) model_mem[i] = '0;

    dec_tab[0]  = '{11'b10001011000, 12'b0000_0001_1000};
    dec_tab[1]  = '{11'b11001011000, 12'b0000_0001_1000};
    dec_tab[2]  = '{11'b10001010000, 12'b0000_0001_1000};
    dec_tab[3]  = '{11'b10101010000, 12'b0000_0001_1000};
    dec_tab[4]  = '{11'b11111000010, 12'b0000_1101_0001};
    dec_tab[5]  = '{11'b11111000000, 12'b1000_0010_0001};
    dec_tab[6]  = '{11'b10110100101, 12'b1010_0000_0100};
    dec_tab[7]  = '{11'b10110101000, 12'b1001_0000_0100};
    dec_tab[8]  = '{11'b00010111111, 12'b0100_0000_0000};
    dec_tab[9]  = '{11'b00000000000, 12'b0};
    dec_tab[10] = '{11'b11111111111, 12'b0};
    dec_tab[11] = '{11'b10110110000, 12'b0};

    pkt_tab[0]  = pv(K_ADD,  5'd3,  64'h0,   64'h0, 64'd5, 64'd7, mk(64'd12, 1, 0, 64'h0));
    pkt_tab[1]  = pv(K_SUB,  5'd4,  64'h0,   64'h0, 64'd0, 64'd1, mk('1, 1, 0, 64'h0));
    pkt_tab[2]  = pv(K_AND,  5'd5,  64'h0,   64'h0, 64'hF0F0, 64'hFF00, mk(64'hF000, 1, 0, 64'h0));
    pkt_tab[3]  = pv(K_ORR,  5'd6,  64'h0,   64'h0, 64'hF0F0, 64'hFF00, mk(64'hFFF0, 1, 0, 64'h0));
    pkt_tab[4]  = pv(K_STUR, 5'd0,  64'h0,   64'd8, 64'd0, 64'hABCD, mk(64'd8, 0, 0, 64'h20));
    pkt_tab[5]  = pv(K_LDUR, 5'd9,  64'h0,   64'd8, 64'd0, 64'd0, mk(64'hABCD, 1, 0, 64'h20));
    pkt_tab[6]  = pv(K_CBZ,  5'd1,  64'h100, 64'd4, 64'd0, 64'd0, mk(64'd0, 0, 1, 64'h110));
    pkt_tab[7]  = pv(K_CBZ,  5'd1,  64'h100, 64'd4, 64'd0, 64'd1, mk(64'd1, 0, 0, 64'h110));
    pkt_tab[8]  = pv(K_CBNZ, 5'd1,  64'h100, 64'd4, 64'd0, 64'd0, mk(64'd0, 0, 0, 64'h110));
    pkt_tab[9]  = pv(K_CBNZ, 5'd1,  64'h100, 64'd4, 64'd0, 64'd1, mk(64'd1, 0, 1, 64'h110));
    pkt_tab[10] = pv(K_B,    5'd2,  64'h200, '1,    64'd3, 64'd4, mk(64'd7, 0, 1, 64'h1FC));
    pkt_tab[11] = pv(K_NOP,  5'd7,  64'h0,   64'h0, 64'd2, 64'd3, mk(64'd5, 0, 0, 64'h0));
    pkt_tab[12] = pv(K_LDUR, 5'd8,  64'h0,   64'd8, 64'h100, 64'd0, mk(64'hABCD, 1, 0, 64'h20));
    pkt_tab[13] = pv(K_STUR, 5'd0,  64'h0,   64'h0, 64'hF8, 64'h55, mk(64'hF8, 0, 0, 64'h0));
    pkt_tab[14] = pv(K_LDUR, 5'd31, 64'h0,   64'h0, 64'h1F8, 64'd0, mk(64'h55, 1, 0, 64'h0));

    // Reset held with a live store packet on the bus: nothing may be captured
    bus.opcode = op_of(K_STUR);
    bus.in_buf = make_pkt(op_of(K_STUR), 5'd7, 64'h44, 64'd0, 64'd0, 64'hDEAD);
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");

    // Decode must work while in reset
    for (int i = 0; i < 12; i++) begin
      bus.opcode = dec_tab[i].op;
      #1 check($sformatf("decode[%0d]", i), 64'(ctl_vec()), 64'(dec_tab[i].ctl));
      $display("decode op=%b ctl=%b", dec_tab[i].op, ctl_vec());
    end

    bus.in_buf = '0;
    bus.opcode = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // The held store must not have reached memory
    run_pkt("post_reset_load", K_LDUR, 5'd1, 64'h0, 64'd0, 64'd0, 64'd0,
            mk(64'd0, 1, 0, 64'h0));

    for (int i = 0; i < 15; i++)
      run_pkt($sformatf("vec[%0d]", i), pkt_tab[i].k, pkt_tab[i].rd, pkt_tab[i].pc,
              pkt_tab[i].imm, pkt_tab[i].d1, pkt_tab[i].d2, pkt_tab[i].e);

    // Store, then reset between edges: outputs clear at once, memory is wiped
    run_pkt("pre_reset_store", K_STUR, 5'd0, 64'h0, 64'd16, 64'd0, 64'h1234,
            mk(64'd16, 0, 0, 64'd64));
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    check("async_reset.ctl", 64'(ctl_vec()), 64'(ctl_model(op_of(K_STUR))));
    for (int i = 0; i < 32; i++) model_mem[i] = '0;
    bus.in_buf = '0;
    bus.opcode = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_pkt("reload_after_reset", K_LDUR, 5'd9, 64'h0, 64'd16, 64'd0, 64'd0,
            mk(64'd0, 1, 0, 64'd64));

    // Random opcode decode
    for (int i = 0; i < 60; i++) begin
      logic [10:0] op;
      op = (i % 3 == 0) ? op_of(kind_t'($urandom_range(0, 9))) : 11'($urandom);
      if (i % 5 == 1) op[10:3] = 8'b10110100 | 8'($urandom_range(0, 1));
      bus.opcode = op;
      #1 check("rand_decode", 64'(ctl_vec()), 64'(ctl_model(op)));
      $display("rand_decode op=%b ctl=%b", op, ctl_vec());
    end

    // Random packets against the instruction-level model
    for (int i = 0; i < 200; i++) begin
      kind_t k;
      logic [63:0] pc, imm, d1, d2;
      logic [4:0] rd;
      k  = kind_t'($urandom_range(0, 9));
      rd = 5'($urandom);
      pc = {$urandom, $urandom};
      d1 = {$urandom, $urandom};
      d2 = {$urandom, $urandom};
      imm = {$urandom, $urandom};
      if (k == K_LDUR || k == K_STUR) begin
        d1  = 64'($urandom_range(0, 511));
        imm = 64'($urandom_range(0, 255));
      end
      if ((k == K_CBZ || k == K_CBNZ) && $urandom_range(0, 1) == 1) d2 = '0;
      run_pkt($sformatf("rand[%0d]", i), k, rd, pc, imm, d1, d2, predict(k, pc, imm, d1, d2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
